spi_slave_tx: RTL and testbench
===============================

SPI_SLAVE_TX -- requirements
Module: spi_slave_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning word length in bits (>=2).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer depth for spi_clk and chip_select.
REQ-003 SHALL have ports, clock and reset first: one clock; reset is synchronous and active-high.
- clock  input  1  system clock; all logic on its rising edge
- reset  input  1  synchronous, active-high reset
- data_in  input  WIDTH  parallel word to transmit
- data_valid  input  1  one-cycle write strobe for data_in
- buf_full  output  1  holding buffer occupied
- spi_clk  input  1  external SPI clock from master, idle low (mode 0)
- chip_select  input  1  external select from master, active-low
- serial_data  output  1  MISO bit, MSB first
- done_flag  output  1  one-cycle pulse per completed word
- over_flow  output  1  one-cycle pulse, write to full buffer
- under_flow  output  1  one-cycle pulse, word started with empty buffer
- abort_flag  output  1  one-cycle pulse, chip_select deasserted mid-word

Function
REQ-004 SHALL pass spi_clk and chip_select through SYNC_STAGES flops, then an edge-detect register producing one-cycle rise/fall pulses.
REQ-005 SHALL support spi_clk high and low phases each >= 4 clock periods; faster spi_clk is out of scope.
REQ-006 SHALL write data_in into a one-word holding buffer when data_valid=1 and buffer empty; buf_full rises the next cycle.
REQ-007 SHALL, on data_valid=1 with buffer full, discard data_in, keep old buffer contents, and pulse over_flow.
REQ-008 SHALL accept a write (no over_flow) when the buffer is emptied by a shifter load in the same cycle.
REQ-009 SHALL implement states IDLE and SHIFT.
REQ-010 IDLE: serial_data=0, bit counter=0; on synchronized chip_select fall, load shifter and go to SHIFT.
REQ-011 Load: if buf_full, shifter<=buffer and buffer emptied; else shifter<=0 and under_flow pulses; serial_data=shifter MSB from the cycle after load.
REQ-012 SHIFT: on spi_clk rise, increment bit counter; on the WIDTH-th rise, pulse done_flag and reset counter to 0.
REQ-013 SHIFT: on spi_clk fall with counter!=0, shift shifter left by one, filling with 0.
REQ-014 SHIFT: on spi_clk fall with counter=0 after a completed word (chip_select still low), perform a load per REQ-011 for back-to-back words.
REQ-015 SHALL, on chip_select rise in SHIFT, return to IDLE; if counter!=0, pulse abort_flag; partially shifted word is discarded, buffer untouched.
REQ-016 Simultaneous chip_select rise and spi_clk edge: chip_select rise wins; the edge is ignored.
REQ-017 spi_clk edges while in IDLE SHALL be ignored.

Reset
REQ-018 On reset: state IDLE, buffer empty, buf_full=0, shifter=0, counter=0, serial_data=0, done_flag=0, over_flow=0, under_flow=0, abort_flag=0, synchronizers to idle levels (spi_clk=0, chip_select=1).
REQ-019 Reset mid-transfer SHALL abandon the word without any flag pulse; the next transfer needs a fresh chip_select fall.

Structure
REQ-020 Shared package spi_pkg SHALL hold the state type (IDLE, SHIFT) and default WIDTH/SYNC_STAGES constants.
REQ-021 Sub-module sync_edge_detect (synchronizer + rise/fall pulse) SHALL be instantiated once for spi_clk and once for chip_select.

Verification
REQ-022 Write 0xA5, CS low, 8 spi_clk pulses, CS high -> serial_data sampled on rises = 1,0,1,0,0,1,0,1; one done_flag; buf_full falls after CS fall; no other flags.
REQ-023 CS low with empty buffer, 8 pulses -> under_flow once at start, 0x00 shifted, done_flag once.
REQ-024 Write 0x3C, CS low, write 0xC3 during word 1, 16 pulses continuous CS -> 0x3C then 0xC3, two done_flag pulses, no under_flow.
REQ-025 Write 0x11 then 0x22 before CS -> over_flow once on second write; 0x11 shifted.
REQ-026 Write 0xF0, CS low, 3 pulses, CS high -> abort_flag once, IDLE, serial_data=0; next write 0x0F transfers correctly.
REQ-027 Reset asserted after 4 bits -> all outputs at reset values next cycle, no flags; subsequent 0x5A transfer correct.

Source files
------------

// File: rtl/spi_pkg.sv
// ============================================================================
// spi_pkg : shared state type and default sizing for the SPI slave transmitter
// Rev 1.0
// ============================================================================
`default_nettype none

package spi_pkg;

    localparam int DEFAULT_WIDTH       = 8;
    localparam int DEFAULT_SYNC_STAGES = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

endpackage

`default_nettype wire

// File: rtl/sync_edge_detect.sv
// ============================================================================
// sync_edge_detect : multi-flop synchronizer followed by rise/fall pulse detect
// Rev 1.0
// ============================================================================
`default_nettype none

module sync_edge_detect #(
    parameter int   SYNC_STAGES = 2,
    parameter logic IDLE_LEVEL  = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic async_i,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    generate
        if (SYNC_STAGES == 1) begin : g_single
            always_ff @(posedge clock) begin
                if (reset) begin
                    sync_q <= IDLE_LEVEL;
                end else begin
                    sync_q <= async_i;
                end
            end
        end else begin : g_chain
            always_ff @(posedge clock) begin
                if (reset) begin
                    sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
                end else begin
                    sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
                end
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            prev_q <= IDLE_LEVEL;
        end else begin
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o =  sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[SYNC_STAGES-1] &  prev_q;

endmodule

`default_nettype wire

// File: rtl/spi_slave_tx.sv
// ============================================================================
// spi_slave_tx : mode-0 SPI slave transmitter (MSB first) with one-word buffer
// Rev 1.0
// ============================================================================
`default_nettype none

module spi_slave_tx
    import spi_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             buf_full,
    input  logic             spi_clk,
    input  logic             chip_select,
    output logic             serial_data,
    output logic             done_flag,
    output logic             over_flow,
    output logic             under_flow,
    output logic             abort_flag
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic sclk_rise, sclk_fall;
    logic cs_rise, cs_fall;

    state_e           state_q;
    logic [WIDTH-1:0] buf_q, buf_d;
    logic             buf_full_q, buf_full_d;
    logic             over_q, over_d;
    logic [WIDTH-1:0] shreg_q;
    logic [CNT_W-1:0] cnt_q;
    logic             word_done_q;
    logic             under_pend_q;
    logic             done_q, under_q, abort_q;
    logic             load_now;
    logic [WIDTH-1:0] load_word;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES),
        .IDLE_LEVEL  (1'b0)
    ) u_sclk_sync (
        .clock   (clock),
        .reset   (reset),
        .async_i (spi_clk),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall)
    );

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES),
        .IDLE_LEVEL  (1'b1)
    ) u_cs_sync (
        .clock   (clock),
        .reset   (reset),
        .async_i (chip_select),
        .rise_o  (cs_rise),
        .fall_o  (cs_fall)
    );

    always_comb begin
        load_now = 1'b0;
        if (state_q == IDLE) begin
            load_now = cs_fall;
        end else begin
            load_now = !cs_rise && sclk_fall && (cnt_q == '0) && word_done_q;
        end
    end

    assign load_word = buf_full_q ? buf_q : '0;

    // A load in the same cycle frees the slot, so the write is taken, not flagged.
    always_comb begin
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        over_d     = 1'b0;
        if (load_now) begin
            buf_full_d = 1'b0;
        end
        if (data_valid) begin
            if (!buf_full_q || load_now) begin
                buf_d      = data_in;
                buf_full_d = 1'b1;
            end else begin
                over_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            over_q     <= 1'b0;
        end else begin
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            over_q     <= over_d;
        end
    end

    // A back-to-back load on the final falling edge is speculative: its
    // underrun is only reported once the master actually clocks that word.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            cnt_q        <= '0;
            word_done_q  <= 1'b0;
            under_pend_q <= 1'b0;
            done_q       <= 1'b0;
            under_q      <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            under_q <= 1'b0;
            abort_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q   <= '0;
                    shreg_q <= '0;
                    if (cs_fall) begin
                        shreg_q      <= load_word;
                        under_q      <= ~buf_full_q;
                        word_done_q  <= 1'b0;
                        under_pend_q <= 1'b0;
                        state_q      <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        state_q      <= IDLE;
                        abort_q      <= (cnt_q != '0);
                        shreg_q      <= '0;
                        cnt_q        <= '0;
                        word_done_q  <= 1'b0;
                        under_pend_q <= 1'b0;
                    end else if (sclk_rise) begin
                        under_q      <= under_pend_q;
                        under_pend_q <= 1'b0;
                        if (cnt_q == LAST_BIT) begin
                            cnt_q       <= '0;
                            done_q      <= 1'b1;
                            word_done_q <= 1'b1;
                        end else begin
                            cnt_q       <= cnt_q + 1'b1;
                            word_done_q <= 1'b0;
                        end
                    end else if (sclk_fall) begin
                        if (cnt_q != '0) begin
                            shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
                        end else if (word_done_q) begin
                            shreg_q      <= load_word;
                            under_pend_q <= ~buf_full_q;
                            word_done_q  <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign buf_full    = buf_full_q;
    assign serial_data = shreg_q[WIDTH-1];
    assign done_flag   = done_q;
    assign over_flow   = over_q;
    assign under_flow  = under_q;
    assign abort_flag  = abort_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_tx.sv
// ============================================================================
// tb_spi_slave_tx : acts as a mode-0 SPI master and checks spi_slave_tx
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_spi_slave_tx;

    localparam int WIDTH = 8;

    logic             clock = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] data_in;
    logic             data_valid;
    logic             spi_clk;
    logic             chip_select;
    logic             buf_full;
    logic             serial_data;
    logic             done_flag, over_flow, under_flow, abort_flag;

    spi_slave_tx #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .buf_full    (buf_full),
        .spi_clk     (spi_clk),
        .chip_select (chip_select),
        .serial_data (serial_data),
        .done_flag   (done_flag),
        .over_flow   (over_flow),
        .under_flow  (under_flow),
        .abort_flag  (abort_flag)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    int cnt_done = 0, cnt_over = 0, cnt_under = 0, cnt_abort = 0;
    int exp_done = 0, exp_over = 0, exp_under = 0, exp_abort = 0;

    // Reference state: buffer occupancy, current word, bits clocked so far.
    bit               mdl_full;
    logic [WIDTH-1:0] mdl_buf;
    logic [WIDTH-1:0] cur_word;
    logic [WIDTH-1:0] rx;
    int               bitcnt;
    bit               pend_under;

    always @(negedge clock) begin
        if (!reset) begin
            cnt_done  += int'(done_flag);
            cnt_over  += int'(over_flow);
            cnt_under += int'(under_flow);
            cnt_abort += int'(abort_flag);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check_counts(input string where);
        check({where, "_done"},  cnt_done,  exp_done);
        check({where, "_over"},  cnt_over,  exp_over);
        check({where, "_under"}, cnt_under, exp_under);
        check({where, "_abort"}, cnt_abort, exp_abort);
    endtask

    task automatic bench_write(input logic [WIDTH-1:0] d);
        @(negedge clock);
        data_in    = d;
        data_valid = 1'b1;
        if (mdl_full) begin
            exp_over++;
        end else begin
            mdl_buf  = d;
            mdl_full = 1'b1;
        end
        @(negedge clock);
        data_valid = 1'b0;
        data_in    = WIDTH'($urandom);
    endtask

    task automatic model_load(input bit chained);
        rx = '0;
        if (mdl_full) begin
            cur_word   = mdl_buf;
            mdl_full   = 1'b0;
            pend_under = 1'b0;
        end else begin
            cur_word = '0;
            if (chained) begin
                pend_under = 1'b1;
            end else begin
                exp_under++;
                pend_under = 1'b0;
            end
        end
    endtask

    task automatic cs_low();
        @(negedge clock);
        chip_select = 1'b0;
        model_load(1'b0);
        bitcnt = 0;
        idle(6);
        check("buf_full_after_cs_fall", buf_full, mdl_full);
        check("under_at_start", cnt_under, exp_under);
    endtask

    task automatic sclk_pulse(input bit do_write, input logic [WIDTH-1:0] wd);
        @(negedge clock);
        rx = {rx[WIDTH-2:0], serial_data};
        if (bitcnt == 0 && pend_under) begin
            exp_under++;
            pend_under = 1'b0;
        end
        spi_clk = 1'b1;
        bitcnt++;
        idle($urandom_range(3, 6));
        if (do_write) begin
            bench_write(wd);
            idle(4);
        end
        @(negedge clock);
        spi_clk = 1'b0;
        if (bitcnt == WIDTH) begin
            exp_done++;
            check("word", rx, cur_word);
            bitcnt = 0;
            model_load(1'b1);
        end
        idle($urandom_range(3, 6));
    endtask

    task automatic cs_high();
        @(negedge clock);
        chip_select = 1'b1;
        if (bitcnt != 0) exp_abort++;
        bitcnt     = 0;
        pend_under = 1'b0;
        idle(6);
        check("serial_idle", serial_data, 1'b0);
        check("buf_full_idle", buf_full, mdl_full);
        check_counts("end");
    endtask

    task automatic idle_sclk_pulse();
        @(negedge clock);
        spi_clk = 1'b1;
        idle(5);
        spi_clk = 1'b0;
        idle(5);
        check("serial_idle_sclk", serial_data, 1'b0);
        check_counts("idle_sclk");
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset       = 1'b1;
        chip_select = 1'b1;
        spi_clk     = 1'b0;
        data_valid  = 1'b0;
        @(negedge clock);
        check("rst_buf_full", buf_full, 1'b0);
        check("rst_serial", serial_data, 1'b0);
        check("rst_flags", {done_flag, over_flow, under_flow, abort_flag}, 4'b0000);
        idle(2);
        reset      = 1'b0;
        mdl_full   = 1'b0;
        bitcnt     = 0;
        pend_under = 1'b0;
        idle(4);
        check_counts("after_rst");
    endtask

    task automatic word_xfer(input int nbits);
        cs_low();
        for (int b = 0; b < nbits; b++) sclk_pulse(1'b0, '0);
        cs_high();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end

    initial begin
        reset       = 1'b1;
        chip_select = 1'b1;
        spi_clk     = 1'b0;
        data_valid  = 1'b0;
        data_in     = '0;
        mdl_full    = 1'b0;
        mdl_buf     = '0;
        cur_word    = '0;
        rx          = '0;
        bitcnt      = 0;
        pend_under  = 1'b0;
        do_reset();

        // Single word 0xA5
        bench_write(8'hA5);
        word_xfer(WIDTH);

        // Empty buffer: underrun, zeros shifted
        word_xfer(WIDTH);

        // Back-to-back words, second written mid-word
        bench_write(8'h3C);
        cs_low();
        for (int b = 0; b < 2 * WIDTH; b++) sclk_pulse(b == 3, 8'hC3);
        cs_high();

        // Overflow on second write; first word kept
        bench_write(8'h11);
        bench_write(8'h22);
        idle(3);
        check("over_once", cnt_over, exp_over);
        word_xfer(WIDTH);

        // Abort after three bits, then a clean word
        bench_write(8'hF0);
        word_xfer(3);
        bench_write(8'h0F);
        word_xfer(WIDTH);

        // Reset in the middle of a word, then a clean word
        bench_write(8'h96);
        cs_low();
        for (int b = 0; b < 4; b++) sclk_pulse(1'b0, '0);
        do_reset();
        bench_write(8'h5A);
        word_xfer(WIDTH);

        // Randomized traffic
        for (int t = 0; t < 30; t++) begin
            int nb;
            if ($urandom_range(0, 1) == 1) bench_write(WIDTH'($urandom));
            if ($urandom_range(0, 3) == 0) bench_write(WIDTH'($urandom));
            if ($urandom_range(0, 4) == 0) idle_sclk_pulse();
            nb = $urandom_range(1, 3 * WIDTH);
            cs_low();
            for (int b = 0; b < nb; b++) sclk_pulse($urandom_range(0, 5) == 0, WIDTH'($urandom));
            cs_high();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
